mem_byte_seq: RTL and testbench
===============================

# mem_byte_seq

Initiator for the byte-wide data port of the shared EBR memory (19-bit byte address, 8-bit write/read data, synchronous read). It accepts one RV32I load/store request at a time from the core, splits it into 1, 2 or 4 little-endian byte accesses on the memory port, and reassembles load data. Loads are sign- or zero-extended to 32 bits. It sits between the core's load/store stage and memory port A.

## Interface
- RD_LAT, 1, memory read latency in cycles from address presentation to valid `mem_rd`. Legal values are 1–2.
- clk  in  1  single clock; every register is updated on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high exactly when the state is IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  19  byte address
- req_wdata  in  32  store data; the low `n` bytes are used
- rsp_valid  out  1  one-cycle pulse; there is no backpressure, so the core must accept it
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal-size request; qualified by `rsp_valid`
- mem_addr  out  19  byte address to the memory port
- mem_wd  out  8  write byte
- mem_we  out  1  write strobe
- mem_rd  in  8  read byte, valid RD_LAT cycles after `mem_addr`

## Operation
- **Byte count:** `n` = 1, 2 or 4 for byte, half and word respectively.
- **Acceptance:** a request is accepted on a clock edge where `req_valid && req_ready`. All request fields are latched at that edge.
- **Error check:** the request is an error when either of these holds:
  - `req_size == 11`
  - half with `addr[0] = 1`, or word with `addr[1:0] != 00`

  An error request goes to DONE with `rsp_err = 1` and issues no memory access. `mem_we` stays 0.
- **States:**
  - IDLE: on a valid error request go to DONE; on any other accepted request go to ISSUE.
  - ISSUE: present bytes `k = 0..n-1` on consecutive cycles. `mem_addr = base + k`.
    - Store: `mem_wd = wdata[8k+7:8k]`, `mem_we = 1`. After the last byte go to DONE.
    - Load: after the last address go to DRAIN.
  - DRAIN: wait RD_LAT cycles while the trailing bytes return, then go to DONE.
  - DONE: drive `rsp_valid` for one cycle, then go to IDLE.
- **Load capture:** a capture counter lags the issue counter by RD_LAT. Byte `k` is sampled from `mem_rd` into `rbuf[8k+7:8k]` during cycle `k + 1 + RD_LAT`, counting from the acceptance cycle as 0. Capture continues through DRAIN.
- **Extension:** applied to `rbuf` when entering DONE.
  - Byte: extend from bit 7.
  - Half: extend from bit 15.
  - Word: pass through unchanged.
- **Address wrap:** aligned accesses never cross the top of the 2^19 space, so no wrap handling is required. The adder wraps modulo 2^19 regardless.
- **Reset mid-operation:** reset returns the FSM to IDLE and cancels any pending response (`rsp_valid` is not asserted). Store bytes already written stay written; there is no rollback.
- **Request during a transfer:** while not in IDLE, `req_ready = 0` and `req_valid` is ignored.

## Timing
- **Reset values:**
  - `mem_addr`, `mem_wd`, `mem_we` = 0
  - `rsp_valid`, `rsp_err` = 0; `rsp_rdata` = 0
  - `req_ready` = 1 (the state is IDLE)
- **Registered outputs:** all `mem_*` and `rsp_*` outputs are registered. `req_ready` is decoded from the state register.
- **Response latency**, counted from the acceptance cycle as 0:
  - Store: memory access in cycles 1..n; `rsp_valid` in cycle n+1.
  - Load: addresses in cycles 1..n; `rsp_valid` in cycle n+RD_LAT+1.
  - Error: `rsp_valid` in cycle 1.
- **Examples at RD_LAT = 1:**
  - Word load: `rsp_valid` in cycle 6.
  - Byte load: `rsp_valid` in cycle 3.
  - Word store: `rsp_valid` in cycle 5.
- **Back-to-back requests:** the earliest next acceptance is the cycle after `rsp_valid`, when the FSM is back in IDLE.
- **Idle memory port:** outside ISSUE, `mem_we = 0`. `mem_addr` and `mem_wd` hold their last values.

## Structure
- **Shared package `mem_pkg`:**
  - size codes SZ_B / SZ_H / SZ_W
  - the state encoding IDLE / ISSUE / DRAIN / DONE
  - address width 19 and data width 8, shared with the memory block
- **Sub-module `load_extend`:** combinational. Inputs are size, unsigned flag and the 32-bit `rbuf`; output is the 32-bit extended result. It is reused by the core's writeback path.
- **Top-level contents:** FSM, issue and capture counters, `rbuf`, and the request latch.

## Test plan
- Word store of 0xDEADBEEF to 0x00100 -> `mem_we` high for 4 cycles with addr/data pairs 0x100/EF, 0x101/BE, 0x102/AD, 0x103/DE; `rsp_valid` in cycle 5 with `rsp_err = 0`.
- Word load from 0x00100 on a memory model holding the previous store -> `rsp_rdata = 0xDEADBEEF` in cycle 6 (RD_LAT = 1); repeat with RD_LAT = 2 -> cycle 7.
- Byte 0x80 at 0x00200, loaded signed -> 0xFFFFFF80; loaded unsigned -> 0x00000080. Half 0x8001 at 0x00202, loaded signed -> 0xFFFF8001.
- Errors, each checked with `mem_we` never asserting:
  - word at 0x00102 -> `rsp_err = 1` in cycle 1
  - half at 0x00101 -> `rsp_err = 1` in cycle 1
  - size 11 -> `rsp_err = 1` in cycle 1
- `rst` asserted in cycle 2 of a word store -> bytes 0 and 1 are written and bytes 2 and 3 are not; no `rsp_valid`; `req_ready = 1` from the next cycle.
- `req_valid` held high with changing fields during a load -> only the first request executes; the second is accepted in the cycle after `rsp_valid`.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-wide EBR memory port and its initiators.
package mem_pkg;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 8;

    // Request size codes; SZ_BAD is the illegal encoding.
    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } state_e;

    // Index of the last byte of an access (n - 1).
    function automatic logic [1:0] last_idx(input size_e sz);
        case (sz)
            SZ_B:    return 2'd0;
            SZ_H:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // Illegal size or an address not aligned to the access size.
    function automatic logic req_is_err(input size_e sz, input logic [1:0] addr_lo);
        return (sz == SZ_BAD) || ((sz == SZ_H) && addr_lo[0]) ||
               ((sz == SZ_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of assembled load data to 32 bits.
module load_extend
    import mem_pkg::*;
(
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [31:0] rbuf,
    output logic [31:0] result
);

    // Replicate the top bit of the loaded field unless zero-extending.
    always_comb begin
        result = rbuf;
        case (size)
            SZ_B:    result = {{24{rbuf[7] & ~is_unsigned}}, rbuf[7:0]};
            SZ_H:    result = {{16{rbuf[15] & ~is_unsigned}}, rbuf[15:0]};
            default: result = rbuf;
        endcase
    end

endmodule

// File: rtl/mem_byte_seq.sv
// Splits one RV32I load/store into little-endian byte accesses on memory port A
// and reassembles load data.
module mem_byte_seq
    import mem_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam int unsigned CAP_TOP = RD_LAT - 1;
    localparam int unsigned IDX_TOP = 2 * RD_LAT - 1;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    size_e             size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rbuf_q, rbuf_d;
    // Capture pipeline: valid flag and byte index of each issued load address,
    // delayed by RD_LAT so it lines up with the returning data.
    logic [RD_LAT-1:0]   cap_v_q;
    logic [2*RD_LAT-1:0] cap_idx_q;
    logic [1:0]          cap_idx;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wd_q, mem_wd_d;
    logic              mem_we_q, mem_we_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              accept, issue_load;
    logic [1:0]        nxt_idx;
    logic [31:0]       ext_data;

    assign req_ready  = (state_q == IDLE);
    assign accept     = req_valid && req_ready;
    assign issue_load = (state_q == ISSUE) && !we_q;
    assign nxt_idx    = cnt_q + 2'd1;
    assign cap_idx    = cap_idx_q[IDX_TOP -: 2];

    assign mem_addr  = mem_addr_q;
    assign mem_wd    = mem_wd_q;
    assign mem_we    = mem_we_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Merge the returning byte into its lane; the last byte is visible here in
    // the same cycle the FSM enters DONE, so extension uses rbuf_d.
    always_comb begin
        rbuf_d = rbuf_q;
        if (accept) begin
            rbuf_d = '0;
        end
        if (cap_v_q[CAP_TOP]) begin
            case (cap_idx)
                2'd0:    rbuf_d[7:0]   = mem_rd;
                2'd1:    rbuf_d[15:8]  = mem_rd;
                2'd2:    rbuf_d[23:16] = mem_rd;
                default: rbuf_d[31:24] = mem_rd;
            endcase
        end
    end

    load_extend u_load_extend (
        .size       (size_q),
        .is_unsigned(uns_q),
        .rbuf       (rbuf_d),
        .result     (ext_data)
    );

    // Next-state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wd_d    = mem_wd_q;
        mem_we_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = size_e'(req_size);
                    uns_d   = req_unsigned;
                    base_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_is_err(size_e'(req_size), req_addr[1:0])) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d    = ISSUE;
                        cnt_d      = 2'd0;
                        mem_addr_d = req_addr;
                        mem_we_d   = req_we;
                        if (req_we) begin
                            mem_wd_d = req_wdata[7:0];
                        end
                    end
                end
            end
            ISSUE: begin
                if (cnt_q == last_idx(size_q)) begin
                    cnt_d = 2'd0;
                    if (we_q) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    cnt_d      = nxt_idx;
                    mem_addr_d = base_q + ADDR_W'(nxt_idx);
                    mem_we_d   = we_q;
                    if (we_q) begin
                        mem_wd_d = DATA_W'(wdata_q >> {nxt_idx, 3'b000});
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == 2'(RD_LAT - 1)) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ext_data;
                end else begin
                    cnt_d = nxt_idx;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request latch, capture pipeline and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            cap_v_q     <= '0;
            cap_idx_q   <= '0;
            mem_addr_q  <= '0;
            mem_wd_q    <= '0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            cap_v_q     <= RD_LAT'({cap_v_q, issue_load});
            cap_idx_q   <= (2 * RD_LAT)'({cap_idx_q, cnt_q});
            mem_addr_q  <= mem_addr_d;
            mem_wd_q    <= mem_wd_d;
            mem_we_q    <= mem_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_mem_byte_seq.sv
// Bench for mem_byte_seq: instance 0 at RD_LAT=1, instance 1 at RD_LAT=2, each
// with its own byte memory. A transaction-level model predicts, per cycle, the
// memory writes, load addresses, responses and req_ready.
module tb_mem_byte_seq;

    logic        clk = 1'b0;
    logic        rst [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we [2];
    logic [1:0]  req_size [2];
    logic        req_unsigned [2];
    logic [18:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err [2];
    logic [18:0] mem_addr [2];
    logic [7:0]  mem_wd [2];
    logic        mem_we [2];
    logic [7:0]  mem_rd [2];

    logic [7:0]  dmem [2][524288];
    logic [7:0]  ref_mem [2][524288];
    logic [7:0]  rd1 [2];
    logic [7:0]  rd2 [2];

    // Expectations keyed by (instance << 20) + cycle.
    logic [32:0] exp_rsp [int];
    logic [26:0] exp_wr [int];
    logic [18:0] exp_rd [int];
    int          acc_c [2];
    int          end_c [2];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_byte_seq #(.RD_LAT(1)) u_dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .mem_addr(mem_addr[0]),
        .mem_wd(mem_wd[0]), .mem_we(mem_we[0]), .mem_rd(mem_rd[0])
    );

    mem_byte_seq #(.RD_LAT(2)) u_dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .mem_addr(mem_addr[1]),
        .mem_wd(mem_wd[1]), .mem_we(mem_we[1]), .mem_rd(mem_rd[1])
    );

    // Synchronous-read memories: one and two cycles of read latency.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_we[d]) dmem[d][mem_addr[d]] <= mem_wd[d];
            rd1[d] <= dmem[d][mem_addr[d]];
            rd2[d] <= rd1[d];
        end
    end
    assign mem_rd[0] = rd1[0];
    assign mem_rd[1] = rd2[1];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout waiting for DUT (cycle %0d)", name, cyc);
    endtask

    // Transaction model: what the port must do for a request accepted in cycle c.
    // abort != 0 is the cycle whose closing edge carries a reset.
    task automatic predict(input int d, input int c, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [18:0] a, input logic [31:0] wd,
                           input int abort);
        int n, lat, kb, rc;
        logic err;
        logic [18:0] ak;
        logic [31:0] v;
        lat = (d == 0) ? 1 : 2;
        kb  = d << 20;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        if (err) begin
            rc = c + 1;
            exp_rsp[kb + rc] = {1'b1, 32'h0};
        end else if (we) begin
            for (int k = 0; k < n; k++) begin
                ak = a + 19'(k);
                if (abort == 0 || c + 1 + k <= abort) begin
                    exp_wr[kb + c + 1 + k] = {ak, wd[8*k +: 8]};
                    ref_mem[d][ak] = wd[8*k +: 8];
                end
            end
            rc = c + n + 1;
            if (abort == 0) exp_rsp[kb + rc] = {1'b0, 32'h0};
        end else begin
            v = 0;
            for (int k = 0; k < n; k++) begin
                ak = a + 19'(k);
                exp_rd[kb + c + 1 + k] = ak;
                v = v | (32'(ref_mem[d][ak]) << (8 * k));
            end
            if (n == 1 && !uns && v[7])  v = v | 32'hFFFF_FF00;
            if (n == 2 && !uns && v[15]) v = v | 32'hFFFF_0000;
            rc = c + n + lat + 1;
            exp_rsp[kb + rc] = {1'b0, v};
        end
        acc_c[d] = c;
        end_c[d] = (abort != 0) ? abort : rc;
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                int key;
                key = (d << 20) + cyc;
                chk($sformatf("req_ready[%0d]", d), req_ready[d],
                    !(cyc > acc_c[d] && cyc <= end_c[d]));
                chk($sformatf("mem_we[%0d]", d), mem_we[d], exp_wr.exists(key));
                if (exp_wr.exists(key)) begin
                    chk($sformatf("wr_addr[%0d]", d), mem_addr[d], exp_wr[key][26:8]);
                    chk($sformatf("wr_data[%0d]", d), mem_wd[d], exp_wr[key][7:0]);
                end
                if (exp_rd.exists(key)) begin
                    chk($sformatf("rd_addr[%0d]", d), mem_addr[d], exp_rd[key]);
                end
                chk($sformatf("rsp_valid[%0d]", d), rsp_valid[d], exp_rsp.exists(key));
                if (exp_rsp.exists(key)) begin
                    chk($sformatf("rsp_err[%0d]", d), rsp_err[d], exp_rsp[key][32]);
                    chk($sformatf("rsp_rdata[%0d]", d), rsp_rdata[d], exp_rsp[key][31:0]);
                end
            end
        end
    end

    // One request; returns response latency from acceptance (or -1), data and error.
    task automatic do_req(input int d, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [18:0] a, input logic [31:0] wd, input int abort_rel,
                          output int rel, output logic [31:0] rd, output logic er);
        int c;
        bit ok;
        rel = -1;
        rd  = '0;
        er  = 1'b0;
        @(negedge clk);
        req_we[d] = we; req_size[d] = sz; req_unsigned[d] = uns;
        req_addr[d] = a; req_wdata[d] = wd; req_valid[d] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready[d]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            req_valid[d] = 1'b0;
            timeout("accept");
            return;
        end
        c = cyc;
        predict(d, c, we, sz, uns, a, wd, (abort_rel != 0) ? c + abort_rel : 0);
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        if (abort_rel != 0) begin
            repeat (abort_rel - 1) @(posedge clk);
            #1 rst[d] = 1'b1;
            @(posedge clk);
            #1 rst[d] = 1'b0;
            return;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid[d]) begin
                rel = cyc - c;
                rd  = rsp_rdata[d];
                er  = rsp_err[d];
                break;
            end
        end
        if (rel < 0) timeout("response");
    endtask

    initial begin
        int rel, ca, cb;
        logic [31:0] rd;
        logic er;
        bit got_b;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 524288; i++) begin
                dmem[d][i] = 8'h00;
                ref_mem[d][i] = 8'h00;
            end
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0;
            req_unsigned[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
            acc_c[d] = -1; end_c[d] = -1;
        end
        repeat (3) @(posedge clk);
        #1 rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset mem_addr", mem_addr[d], 0);
            chk("reset mem_wd", mem_wd[d], 0);
            chk("reset mem_we", mem_we[d], 0);
            chk("reset rsp_valid", rsp_valid[d], 0);
            chk("reset rsp_err", rsp_err[d], 0);
            chk("reset rsp_rdata", rsp_rdata[d], 0);
            chk("reset req_ready", req_ready[d], 1);
        end
        chk_en = 1'b1;

        // RD_LAT = 1 instance
        do_req(0, 1, 2'd2, 0, 19'h100, 32'hDEADBEEF, 0, rel, rd, er);
        chk("st_w latency", rel, 5);
        chk("st_w err", er, 0);
        do_req(0, 0, 2'd2, 0, 19'h100, 32'h0, 0, rel, rd, er);
        chk("ld_w latency", rel, 6);
        chk("ld_w data", rd, 32'hDEADBEEF);
        do_req(0, 1, 2'd0, 0, 19'h200, 32'h0000_0080, 0, rel, rd, er);
        chk("st_b latency", rel, 2);
        do_req(0, 0, 2'd0, 0, 19'h200, 32'h0, 0, rel, rd, er);
        chk("ld_b latency", rel, 3);
        chk("ld_b signed", rd, 32'hFFFFFF80);
        do_req(0, 0, 2'd0, 1, 19'h200, 32'h0, 0, rel, rd, er);
        chk("ld_bu", rd, 32'h00000080);
        do_req(0, 1, 2'd1, 0, 19'h202, 32'h0000_8001, 0, rel, rd, er);
        chk("st_h latency", rel, 3);
        do_req(0, 0, 2'd1, 0, 19'h202, 32'h0, 0, rel, rd, er);
        chk("ld_h latency", rel, 4);
        chk("ld_h signed", rd, 32'hFFFF8001);
        do_req(0, 0, 2'd1, 1, 19'h202, 32'h0, 0, rel, rd, er);
        chk("ld_hu", rd, 32'h00008001);
        do_req(0, 0, 2'd0, 0, 19'h203, 32'h0, 0, rel, rd, er);
        chk("ld_b lane3", rd, 32'hFFFFFF80);
        do_req(0, 0, 2'd2, 0, 19'h200, 32'h0, 0, rel, rd, er);
        chk("ld_w mixed", rd, 32'h80010080);

        // Error requests, including stores that must not touch memory.
        do_req(0, 1, 2'd2, 0, 19'h102, 32'hFFFFFFFF, 0, rel, rd, er);
        chk("err_w latency", rel, 1);
        chk("err_w flag", er, 1);
        do_req(0, 1, 2'd1, 0, 19'h101, 32'hFFFFFFFF, 0, rel, rd, er);
        chk("err_h flag", er, 1);
        chk("err_h latency", rel, 1);
        do_req(0, 1, 2'd3, 0, 19'h100, 32'hFFFFFFFF, 0, rel, rd, er);
        chk("err_sz flag", er, 1);
        chk("err_sz rdata", rd, 0);
        do_req(0, 0, 2'd2, 0, 19'h100, 32'h0, 0, rel, rd, er);
        chk("ld_w after errors", rd, 32'hDEADBEEF);

        // Reset during cycle 2 of a word store.
        do_req(0, 1, 2'd2, 0, 19'h400, 32'h11223344, 2, rel, rd, er);
        chk("abort byte0", dmem[0][19'h400], 8'h44);
        chk("abort byte1", dmem[0][19'h401], 8'h33);
        chk("abort byte2", dmem[0][19'h402], 8'h00);
        chk("abort byte3", dmem[0][19'h403], 8'h00);
        do_req(0, 0, 2'd2, 1, 19'h400, 32'h0, 0, rel, rd, er);
        chk("ld after abort", rd, 32'h00003344);

        // req_valid held high with changing fields during a word load.
        @(negedge clk);
        req_we[0] = 1'b0; req_size[0] = 2'd2; req_unsigned[0] = 1'b0;
        req_addr[0] = 19'h100; req_wdata[0] = 32'h0; req_valid[0] = 1'b1;
        ca = cyc;
        predict(0, ca, 1'b0, 2'd2, 1'b0, 19'h100, 32'h0, 0);
        @(posedge clk);
        got_b = 1'b0;
        cb = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            req_we[0] = 1'b1; req_size[0] = 2'd0;
            req_addr[0] = 19'h300 + 19'(i); req_wdata[0] = 32'h50 + 32'(i);
            @(negedge clk);
            if (req_ready[0]) begin
                cb = cyc;
                predict(0, cb, 1'b1, 2'd0, 1'b0, req_addr[0], req_wdata[0], 0);
                got_b = 1'b1;
                break;
            end
            @(posedge clk);
        end
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        if (!got_b) timeout("hold accept");
        else chk("hold gap", cb - ca, 7);
        repeat (4) @(negedge clk);
        chk("hold store byte", dmem[0][19'h306], 8'h56);

        // RD_LAT = 2 instance
        do_req(1, 1, 2'd2, 0, 19'h100, 32'hDEADBEEF, 0, rel, rd, er);
        chk("lat2 st_w latency", rel, 5);
        do_req(1, 0, 2'd2, 0, 19'h100, 32'h0, 0, rel, rd, er);
        chk("lat2 ld_w latency", rel, 7);
        chk("lat2 ld_w data", rd, 32'hDEADBEEF);
        do_req(1, 0, 2'd0, 0, 19'h100, 32'h0, 0, rel, rd, er);
        chk("lat2 ld_b latency", rel, 4);
        chk("lat2 ld_b data", rd, 32'hFFFFFFEF);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
